gate2_truth_checker: RTL

//  Sequential driver/checker on the far side of a 2-input gate's A,B->Y interface.
//  On start, drives all four {A,B} vectors to the gate under test, waits a settle time, and samples Y.

---
 rtl/gate2_truth_checker_pkg.sv | 39 +++
 rtl/gate2_truth_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gate2_truth_checker_pkg.sv
// ----------------------------------------------------------------------------
// gate2_truth_checker_pkg
//   Shared definitions for the 2-input gate truth-table checker: FSM state
//   encoding, common truth-table constants, result payload and the table
//   lookup helper.
// ----------------------------------------------------------------------------
package gate2_truth_checker_pkg;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned VEC_W   = 2;
    localparam int unsigned ERR_W   = 3;

    // Expected Y indexed by {A,B}; bit3 is A=1,B=1.
    localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Sweep result payload, cleared on every accepted start.
    typedef struct packed {
        logic               pass;
        logic [ERR_W-1:0]   err_count;
        logic [NUM_VEC-1:0] fail_vec;
    } result_t;

    // Expected gate output for one input vector.
    function automatic logic tt_lookup(input logic [NUM_VEC-1:0] tt,
                                       input logic [VEC_W-1:0]   vec);
        return tt[vec];
    endfunction

endpackage : gate2_truth_checker_pkg

// File: rtl/gate2_truth_checker.sv
// ----------------------------------------------------------------------------
// gate2_truth_checker
//   Drives all four {A,B} vectors into an external 2-input gate, holds each
//   for SETTLE_CYCLES cycles, samples Y, and compares it with TRUTH_TABLE.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (sampled only in IDLE)
//   A, B       out  registered gate inputs
//   Y          in   gate output under test
//   busy       out  high while settling/checking
//   done       out  one-cycle pulse at sweep completion
//   pass       out  1 iff no vector mismatched; valid from done
//   err_count  out  number of mismatching vectors (0..4)
//   fail_vec   out  bit i set if vector {A,B}=i mismatched
// ----------------------------------------------------------------------------
module gate2_truth_checker
    import gate2_truth_checker_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE   = TT_AND,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             Y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    // A zero settle time would leave no cycle for Y to respond.
    if (SETTLE_CYCLES == 0) begin : g_bad_settle
        $error("gate2_truth_checker: SETTLE_CYCLES must be >= 1");
    end

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX   = VEC_W'(NUM_VEC - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   idx_q,   idx_d;
    logic [VEC_W-1:0]   ab_q,    ab_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    result_t            res_q,   res_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               mismatch_c;

    // X/Z on Y must count as a mismatch, hence the case-inequality.
    assign mismatch_c = (Y !== tt_lookup(TRUTH_TABLE, ab_q));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        idx_d  = idx_q;
        ab_d   = ab_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        done_d = 1'b0;
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);

        unique case (state_q)
            ST_IDLE: begin
                // Accepting a sweep clears the previous results.
                if (start) begin
                    idx_d = '0;
                    ab_d  = '0;
                    cnt_d = CNT_RELOAD;
                    res_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    res_d.fail_vec[idx_q] = 1'b1;
                    res_d.err_count       = res_q.err_count + ERR_W'(1);
                end
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + VEC_W'(1);
                    ab_d  = idx_q + VEC_W'(1);
                    cnt_d = CNT_RELOAD;
                end else begin
                    // pass and done become visible together in DONE.
                    done_d     = 1'b1;
                    res_d.pass = (res_d.fail_vec == '0);
                end
            end
            ST_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            ab_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            ab_q   <= ab_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = res_q.pass;
    assign err_count = res_q.err_count;
    assign fail_vec  = res_q.fail_vec;

endmodule : gate2_truth_checker
